// File: rtl/lcd_pkg.sv
// Shared LCD definitions: panel geometry defaults, ball FSM state encoding
// and RGB565 colour constants.
package lcd_pkg;

  localparam int LCD_WIDTH  = 800;
  localparam int LCD_HEIGHT = 480;

  // Ball motion FSM states (plain constants for compatibility with older tools)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WAIT_VS = 3'd1;
  localparam state_t ST_MOVE_X  = 3'd2;
  localparam state_t ST_MOVE_Y  = 3'd3;
  localparam state_t ST_COMMIT  = 3'd4;

  // RGB565 colours
  localparam logic [4:0] WHITE_R = 5'd31;
  localparam logic [5:0] WHITE_G = 6'd63;
  localparam logic [4:0] WHITE_B = 5'd31;
  localparam logic [4:0] BLACK_R = 5'd0;
  localparam logic [5:0] BLACK_G = 6'd0;
  localparam logic [4:0] BLACK_B = 5'd0;

endpackage

// File: rtl/ball_overlay.sv
// Ball overlay: compares the current pixel against the ball square and
// muxes white / background / black into registered LCD colour outputs.
module ball_overlay
  import lcd_pkg::*;
#(
  parameter int BALL_SIZE = 32
) (
  input  logic        PixelClk,
  input  logic        Reset,
  input  logic [15:0] pixel_x,
  input  logic [15:0] pixel_y,
  input  logic        pixel_de,
  input  logic [4:0]  bg_R,
  input  logic [5:0]  bg_G,
  input  logic [4:0]  bg_B,
  input  logic [15:0] ball_x,
  input  logic [15:0] ball_y,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic        LCD_DE
);

  logic [16:0] x_end;
  logic [16:0] y_end;
  logic        hit_p0;

  // Stage p0: combinational hit test; 17-bit ends so ball near 0xFFFF cannot wrap
  always_comb begin
    x_end  = {1'b0, ball_x} + 17'(BALL_SIZE);
    y_end  = {1'b0, ball_y} + 17'(BALL_SIZE);
    hit_p0 = pixel_de
             && (pixel_x >= ball_x) && ({1'b0, pixel_x} < x_end)
             && (pixel_y >= ball_y) && ({1'b0, pixel_y} < y_end);
  end

  // Stage p1: registered colour mux and delayed data enable
  always_ff @(posedge PixelClk or posedge Reset) begin
    if (Reset) begin
      LCD_R  <= BLACK_R;
      LCD_G  <= BLACK_G;
      LCD_B  <= BLACK_B;
      LCD_DE <= 1'b0;
    end else begin
      LCD_DE <= pixel_de;
      if (hit_p0) begin
        LCD_R <= WHITE_R;
        LCD_G <= WHITE_G;
        LCD_B <= WHITE_B;
      end else if (pixel_de) begin
        LCD_R <= bg_R;
        LCD_G <= bg_G;
        LCD_B <= bg_B;
      end else begin
        LCD_R <= BLACK_R;
        LCD_G <= BLACK_G;
        LCD_B <= BLACK_B;
      end
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Bouncing ball controller: once per frame (VSYNC rising edge) steps the
// ball position axis by axis into shadow registers, then commits both at
// once so the visible position never shows a half-updated frame.
module ball_motion_ctrl
  import lcd_pkg::*;
#(
  parameter int WIDTH     = LCD_WIDTH,
  parameter int HEIGHT    = LCD_HEIGHT,
  parameter int BALL_SIZE = 32,
  parameter int SPEED_X   = 4,
  parameter int SPEED_Y   = 3
) (
  input  logic        PixelClk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        LCD_VSYNC,
  input  logic [15:0] pixel_x,
  input  logic [15:0] pixel_y,
  input  logic        pixel_de,
  input  logic [4:0]  bg_R,
  input  logic [5:0]  bg_G,
  input  logic [4:0]  bg_B,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic        LCD_DE,
  output logic [15:0] ball_x,
  output logic [15:0] ball_y,
  output logic [7:0]  bounce_cnt
);

  localparam logic [15:0] X_MAX  = 16'(WIDTH - BALL_SIZE);
  localparam logic [15:0] Y_MAX  = 16'(HEIGHT - BALL_SIZE);
  localparam logic [15:0] X_HOME = 16'((WIDTH - BALL_SIZE) / 2);
  localparam logic [15:0] Y_HOME = 16'((HEIGHT - BALL_SIZE) / 2);
  localparam logic [15:0] SPD_X  = 16'(SPEED_X);
  localparam logic [15:0] SPD_Y  = 16'(SPEED_Y);

  // One-axis step with clamping at both walls; returns {flip, next_pos}.
  // The low wall is tested before subtracting so no value ever goes negative.
  function automatic logic [16:0] bounce_step(input logic [15:0] pos,
                                              input logic        up,
                                              input logic [15:0] spd,
                                              input logic [15:0] lim);
    logic [16:0] r;
    if (up) begin
      if (({1'b0, pos} + {1'b0, spd}) >= {1'b0, lim}) r = {1'b1, lim};
      else                                             r = {1'b0, pos + spd};
    end else begin
      if (pos < spd) r = {1'b1, 16'd0};
      else           r = {1'b0, pos - spd};
    end
    return r;
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic        vs_d;
  logic        frame_tick;
  logic [15:0] shadow_x;
  logic [15:0] shadow_y;
  logic        dir_x;      // 1 = moving right
  logic        dir_y;      // 1 = moving down
  logic        flip_x;
  logic        flip_y;
  logic [16:0] step_x;
  logic [16:0] step_y;

  assign frame_tick = LCD_VSYNC & ~vs_d;

  // VSYNC history; resets high so a VSYNC already high at release is not a tick
  always_ff @(posedge PixelClk or posedge Reset) begin
    if (Reset) vs_d <= 1'b1;
    else       vs_d <= LCD_VSYNC;
  end

  // Next-state logic; ticks outside WAIT_VS are dropped, not remembered
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (Enable) state_nxt = ST_WAIT_VS;
      ST_WAIT_VS: begin
        if (frame_tick)   state_nxt = ST_MOVE_X;
        else if (!Enable) state_nxt = ST_IDLE;
      end
      ST_MOVE_X:  state_nxt = ST_MOVE_Y;
      ST_MOVE_Y:  state_nxt = ST_COMMIT;
      ST_COMMIT:  state_nxt = Enable ? ST_WAIT_VS : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge PixelClk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Candidate next positions from the committed position and direction
  always_comb begin
    step_x = bounce_step(ball_x, dir_x, SPD_X, X_MAX);
    step_y = bounce_step(ball_y, dir_y, SPD_Y, Y_MAX);
  end

  // Position update: X in MOVE_X, Y in MOVE_Y, both made visible in COMMIT
  always_ff @(posedge PixelClk or posedge Reset) begin
    if (Reset) begin
      shadow_x   <= X_HOME;
      shadow_y   <= Y_HOME;
      ball_x     <= X_HOME;
      ball_y     <= Y_HOME;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      flip_x     <= 1'b0;
      flip_y     <= 1'b0;
      bounce_cnt <= 8'd0;
    end else begin
      case (state)
        ST_MOVE_X: begin
          shadow_x <= step_x[15:0];
          flip_x   <= step_x[16];
          if (step_x[16]) dir_x <= ~dir_x;
        end
        ST_MOVE_Y: begin
          shadow_y <= step_y[15:0];
          flip_y   <= step_y[16];
          if (step_y[16]) dir_y <= ~dir_y;
        end
        ST_COMMIT: begin
          ball_x <= shadow_x;
          ball_y <= shadow_y;
          // A corner hit flips both axes but is still a single bouncing frame
          if (flip_x | flip_y) bounce_cnt <= bounce_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  ball_overlay #(
    .BALL_SIZE (BALL_SIZE)
  ) u_overlay (
    .PixelClk (PixelClk),
    .Reset    (Reset),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .pixel_de (pixel_de),
    .bg_R     (bg_R),
    .bg_G     (bg_G),
    .bg_B     (bg_B),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .LCD_R    (LCD_R),
    .LCD_G    (LCD_G),
    .LCD_B    (LCD_B),
    .LCD_DE   (LCD_DE)
  );

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: a default-size instance plus a tiny 64x64
// instance whose ball hits corners every few frames (fast wrap of bounce_cnt).
module tb_ball_motion_ctrl;

  logic        PixelClk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic        LCD_VSYNC;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic        pixel_de;
  logic [4:0]  bg_R;
  logic [5:0]  bg_G;
  logic [4:0]  bg_B;

  logic [4:0]  a_R, b_R;
  logic [5:0]  a_G, b_G;
  logic [4:0]  a_B, b_B;
  logic        a_DE, b_DE;
  logic [15:0] a_bx, a_by, b_bx, b_by;
  logic [7:0]  a_cnt, b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: index 0 = default instance, 1 = small instance
  int m_w[2]  = '{800, 64};
  int m_h[2]  = '{480, 64};
  int m_b[2]  = '{32, 32};
  int m_sx[2] = '{4, 16};
  int m_sy[2] = '{3, 16};
  int mx[2], my[2], mdx[2], mdy[2], mcnt[2];

  always #5 PixelClk = ~PixelClk;

  ball_motion_ctrl dut_a (
    .PixelClk (PixelClk), .Reset (Reset), .Enable (Enable), .LCD_VSYNC (LCD_VSYNC),
    .pixel_x (pixel_x), .pixel_y (pixel_y), .pixel_de (pixel_de),
    .bg_R (bg_R), .bg_G (bg_G), .bg_B (bg_B),
    .LCD_R (a_R), .LCD_G (a_G), .LCD_B (a_B), .LCD_DE (a_DE),
    .ball_x (a_bx), .ball_y (a_by), .bounce_cnt (a_cnt)
  );

  ball_motion_ctrl #(
    .WIDTH (64), .HEIGHT (64), .BALL_SIZE (32), .SPEED_X (16), .SPEED_Y (16)
  ) dut_b (
    .PixelClk (PixelClk), .Reset (Reset), .Enable (Enable), .LCD_VSYNC (LCD_VSYNC),
    .pixel_x (pixel_x), .pixel_y (pixel_y), .pixel_de (pixel_de),
    .bg_R (bg_R), .bg_G (bg_G), .bg_B (bg_B),
    .LCD_R (b_R), .LCD_G (b_G), .LCD_B (b_B), .LCD_DE (b_DE),
    .ball_x (b_bx), .ball_y (b_by), .bounce_cnt (b_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge PixelClk);
    #1;
  endtask

  // Move one axis by speed in its direction; clamp into [0, lim] and reverse on contact
  function automatic void axis_step(input int pos, input int dir, input int spd, input int lim,
                                    output int npos, output int ndir);
    npos = pos + dir * spd;
    ndir = dir;
    if (dir > 0 && npos >= lim) begin
      npos = lim;
      ndir = -1;
    end else if (dir < 0 && npos < 0) begin
      npos = 0;
      ndir = 1;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = (m_w[i] - m_b[i]) / 2;
      my[i] = (m_h[i] - m_b[i]) / 2;
      mdx[i] = 1;
      mdy[i] = 1;
      mcnt[i] = 0;
    end
  endfunction

  function automatic void model_frame();
    int nx, ny, ndx, ndy;
    for (int i = 0; i < 2; i++) begin
      axis_step(mx[i], mdx[i], m_sx[i], m_w[i] - m_b[i], nx, ndx);
      axis_step(my[i], mdy[i], m_sy[i], m_h[i] - m_b[i], ny, ndy);
      if (ndx != mdx[i] || ndy != mdy[i]) mcnt[i] = (mcnt[i] + 1) % 256;
      mx[i] = nx; my[i] = ny; mdx[i] = ndx; mdy[i] = ndy;
    end
  endfunction

  function automatic logic [15:0] exp_pix(input int i, input int px, input int py,
                                          input bit de, input logic [15:0] bg);
    if (!de) return 16'h0000;
    if (px >= mx[i] && px < mx[i] + m_b[i] && py >= my[i] && py < my[i] + m_b[i])
      return 16'hFFFF;
    return bg;
  endfunction

  task automatic check_state(input string tag);
    check_val({tag, "_a_x"},   a_bx,  mx[0]);
    check_val({tag, "_a_y"},   a_by,  my[0]);
    check_val({tag, "_a_cnt"}, a_cnt, mcnt[0]);
    check_val({tag, "_b_x"},   b_bx,  mx[1]);
    check_val({tag, "_b_y"},   b_by,  my[1]);
    check_val({tag, "_b_cnt"}, b_cnt, mcnt[1]);
  endtask

  // Drive one pixel, clock once, compare both overlays against the model
  task automatic pix(input string tag, input int px, input int py, input bit de,
                     input logic [15:0] bg);
    logic [15:0] ea, eb;
    pixel_x = 16'(px); pixel_y = 16'(py); pixel_de = de;
    bg_R = bg[15:11]; bg_G = bg[10:5]; bg_B = bg[4:0];
    ea = exp_pix(0, px, py, de, bg);
    eb = exp_pix(1, px, py, de, bg);
    cyc(1);
    check_val({tag, "_a_rgb"}, {a_R, a_G, a_B}, ea);
    check_val({tag, "_a_de"},  a_DE, de);
    check_val({tag, "_b_rgb"}, {b_R, b_G, b_B}, eb);
    check_val({tag, "_b_de"},  b_DE, de);
  endtask

  task automatic rand_pix(input int n);
    int t, px, py;
    for (int k = 0; k < n; k++) begin
      t  = $urandom_range(0, 1);
      px = (mx[t] > 8 ? mx[t] - 8 : 0) + $urandom_range(0, 47);
      py = (my[t] > 8 ? my[t] - 8 : 0) + $urandom_range(0, 47);
      pix("ovl", px, py, ($urandom_range(0, 7) != 0), 16'($urandom));
    end
  endtask

  // One VSYNC pulse with room for the update; accept tells the model to step
  task automatic frame(input bit accept);
    int hi, total;
    hi    = $urandom_range(1, 3);
    total = 5 + $urandom_range(0, 2);
    LCD_VSYNC = 1'b1;
    cyc(hi);
    LCD_VSYNC = 1'b0;
    cyc(total - hi);
    if (accept) model_frame();
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b0; LCD_VSYNC = 1'b0;
    pixel_x = 16'd384; pixel_y = 16'd224; pixel_de = 1'b1;
    bg_R = 5'd3; bg_G = 6'd5; bg_B = 5'd7;
    model_reset();
    cyc(3);
    check_val("rst_a_x", a_bx, 384);
    check_val("rst_a_y", a_by, 224);
    check_val("rst_a_cnt", a_cnt, 0);
    check_val("rst_a_rgb", {a_R, a_G, a_B}, 0);
    check_val("rst_a_de", a_DE, 0);
    check_state("rst");
    Reset = 1'b0;
    cyc(2);

    // Overlay with ball at (384,224)
    pix("ovl_hit", 384, 224, 1'b1, 16'h1234);
    check_val("ovl_hit_white", {a_R, a_G, a_B}, 16'hFFFF);
    pix("ovl_edge", 416, 224, 1'b1, 16'h1234);
    check_val("ovl_edge_bg", {a_R, a_G, a_B}, 16'h1234);
    pix("ovl_corner_in", 415, 255, 1'b1, 16'h0F0F);
    pix("ovl_de0", 384, 224, 1'b0, 16'h1234);
    check_val("ovl_de0_black", {a_R, a_G, a_B}, 0);

    // First frame: commit lands 3 cycles after the tick edge
    Enable = 1'b1;
    cyc(2);
    LCD_VSYNC = 1'b1;
    cyc(1);
    cyc(2);
    check_val("lat_before_x", a_bx, 384);
    cyc(1);
    check_val("lat_commit_x", a_bx, 388);
    check_val("lat_commit_y", a_by, 227);
    check_val("lat_commit_cnt", a_cnt, 0);
    model_frame();
    LCD_VSYNC = 1'b0;
    cyc(2);
    check_state("first");

    // Second VSYNC edge during MOVE_Y is dropped
    LCD_VSYNC = 1'b1;
    cyc(1);
    LCD_VSYNC = 1'b0;
    cyc(1);
    LCD_VSYNC = 1'b1;
    cyc(6);
    model_frame();
    check_val("dbl_a_x", a_bx, 392);
    check_val("dbl_a_y", a_by, 230);
    check_state("dbl");
    LCD_VSYNC = 1'b0;
    cyc(2);

    // Randomized frames: normal, disabled (ignored), and Enable drop mid-update
    for (int f = 0; f < 700; f++) begin
      int v;
      v = $urandom_range(0, 9);
      if (v == 0) begin
        Enable = 1'b0;
        cyc(2);
        frame(1'b0);
        Enable = 1'b1;
        cyc(2);
      end else if (v == 1) begin
        LCD_VSYNC = 1'b1;
        cyc(1);
        Enable = 1'b0;
        cyc(1);
        LCD_VSYNC = 1'b0;
        cyc(4);
        model_frame();
        Enable = 1'b1;
        cyc(2);
      end else begin
        frame(1'b1);
      end
      check_state("rnd");
      rand_pix(2);
    end
    pixel_de = 1'b0;

    // Reset asserted during MOVE_X: immediate home position, no later commit
    LCD_VSYNC = 1'b1;
    cyc(1);
    Reset = 1'b1;
    #1;
    model_reset();
    check_val("midrst_a_x", a_bx, 384);
    check_val("midrst_a_y", a_by, 224);
    check_state("midrst");
    cyc(2);
    Reset = 1'b0;
    cyc(6);
    check_state("post_rst");
    LCD_VSYNC = 1'b0;
    cyc(2);
    frame(1'b1);
    check_val("post_rst_frame_x", a_bx, 388);
    check_state("post_rst_frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
BALL_MOTION_CTRL -- requirements
Module: ball_motion_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 800, active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480, active lines per frame.
REQ-003 SHALL have parameter BALL_SIZE, default 32, square ball edge in pixels.
REQ-004 SHALL have parameters SPEED_X, default 4, and SPEED_Y, default 3, pixels moved per frame.
REQ-005 SHALL have port PixelClk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port Enable  in  1  motion enable, level.
REQ-008 SHALL have port LCD_VSYNC  in  1  vertical sync from timing generator; rising edge marks frame boundary.
REQ-009 SHALL have ports pixel_x and pixel_y  in  16 each  active-area coordinates of the current pixel.
REQ-010 SHALL have port pixel_de  in  1  data enable for the current pixel.
REQ-011 SHALL have ports bg_R, bg_G and bg_B  in  5/6/5  background color of the current pixel.
REQ-012 SHALL have ports LCD_R, LCD_G and LCD_B  out  5/6/5  composited color, registered.
REQ-013 SHALL have port LCD_DE  out  1  pixel_de delayed by one cycle.
REQ-014 SHALL have ports ball_x and ball_y  out  16 each  committed top-left ball position.
REQ-015 SHALL have port bounce_cnt  out  8  count of frames containing at least one bounce; wraps 255->0.

Function
REQ-016 SHALL detect a frame tick as LCD_VSYNC registered-low and current-high; one tick per rising edge.
REQ-017 SHALL use FSM states IDLE, WAIT_VS, MOVE_X, MOVE_Y, COMMIT.
REQ-018 Transitions SHALL be:
- IDLE->WAIT_VS when Enable=1.
- WAIT_VS->MOVE_X on a frame tick.
- MOVE_X->MOVE_Y->COMMIT unconditionally.
- COMMIT->WAIT_VS if Enable=1, else IDLE.
- WAIT_VS->IDLE when Enable=0 and no tick is present that cycle.
REQ-019 Frame ticks arriving in MOVE_X, MOVE_Y or COMMIT SHALL be ignored, not queued.
REQ-020 Deasserting Enable in MOVE_X or MOVE_Y SHALL NOT abort the update; it SHALL complete through COMMIT.
REQ-021 MOVE_X SHALL compute next x into a shadow register:
- When dir_x=+ and x+SPEED_X >= WIDTH-BALL_SIZE, next x SHALL be WIDTH-BALL_SIZE and dir_x SHALL flip.
- When dir_x=- and x < SPEED_X, next x SHALL be 0 and dir_x SHALL flip.
- Otherwise next x SHALL be x±SPEED_X.
REQ-022 MOVE_Y SHALL apply the same rule using y, SPEED_Y, HEIGHT and dir_y.
REQ-023 COMMIT SHALL copy the shadow values to ball_x/ball_y in one cycle; ball_x/ball_y SHALL change only in COMMIT.
REQ-024 bounce_cnt SHALL increment exactly once in COMMIT when either axis flipped in that frame; a corner hit SHALL count as one.
REQ-025 All arithmetic SHALL be 16-bit unsigned with no negative intermediate; the underflow check SHALL precede subtraction.
REQ-026 hit SHALL be asserted when all of the following hold:
- pixel_de=1.
- ball_x <= pixel_x < ball_x+BALL_SIZE.
- ball_y <= pixel_y < ball_y+BALL_SIZE.
REQ-027 Registered output SHALL be white (R=31, G=63, B=31) on hit, bg color when pixel_de=1 and no hit, and 0 when pixel_de=0.
REQ-028 Latency from pixel inputs to LCD_R/G/B/DE SHALL be exactly 1 cycle.

Reset
REQ-029 Reset SHALL asynchronously force:
- state=IDLE.
- ball_x=384 and ball_y=224, i.e. (WIDTH-BALL_SIZE)/2 and (HEIGHT-BALL_SIZE)/2.
- shadow registers equal to ball_x/ball_y.
- dir_x=+ and dir_y=+.
- bounce_cnt=0.
- LCD_R/G/B=0 and LCD_DE=0.
- VSYNC history register=1, so no spurious tick occurs after release.
REQ-030 Reset asserted mid-update SHALL discard shadow values; no partial commit SHALL occur.

Structure
REQ-031 A shared package lcd_pkg SHALL hold WIDTH/HEIGHT defaults, the FSM state enumeration and RGB565 white/black constants.
REQ-032 The pixel compare and color mux SHALL be one sub-module, ball_overlay; the FSM and position registers SHALL stay in ball_motion_ctrl.

Verification
REQ-033 Reset released, Enable=1, one VSYNC rising edge -> ball_x=388 and ball_y=227 in the COMMIT cycle, 3 cycles after the tick; bounce_cnt=0.
REQ-034 Preset x=766, dir_x=+, one tick -> ball_x=768, dir_x=-, bounce_cnt=1; next tick -> ball_x=764.
REQ-035 Preset x=2, y=1, dir_x=- and dir_y=- (corner), one tick -> ball_x=0, ball_y=0, both dirs flip, bounce_cnt increments by 1 only.
REQ-036 Second VSYNC edge injected during MOVE_Y -> ignored; position advances once only.
REQ-037 Ball at (384,224), pixel_de=1, pixel (384,224) -> next cycle white; pixel (416,224) -> bg; pixel_de=0 -> 0.
REQ-038 Reset asserted in MOVE_X -> ball_x/ball_y immediately 384/224, state IDLE, no commit after release.
